// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM states, owner encoding
// and the latency counter width.
package mem_arb_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/arb_latency_counter.sv
// Down-counter that times the RAM access: loads LATENCY-1 on the strobe,
// then decrements to zero and holds there.
module arb_latency_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Define MEM_ARB_FAIR_EN to let a starved fetch win after STARVE_MAX lost arbitrations.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  output logic              if_stall_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ready_o,
  output logic              mem_stall_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              grant_if;

`ifdef MEM_ARB_FAIR_EN
  localparam bit         FAIR_EN    = 1'b1;
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0] starve_q, starve_d;

  // A fetch that has lost STARVE_LIM arbitrations in a row overrides MEM once.
  always_comb begin
    starve_d = starve_q;
    grant_if = if_req_i & (~mem_req_i | (starve_q >= STARVE_LIM));
    if ((state_q == IDLE) && (if_req_i | mem_req_i)) begin
      if (grant_if) begin
        starve_d = '0;
      end else if (if_req_i) begin
        starve_d = starve_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  localparam bit FAIR_EN = 1'b0;

  always_comb begin
    grant_if = if_req_i & ~mem_req_i;
  end
`endif

  if ((LATENCY < 1) || (LATENCY > 15) ||
      (FAIR_EN && ((STARVE_MAX < 1) || (STARVE_MAX > 7)))) begin : g_param_check
    $error("mem_port_arbiter: LATENCY must be 1..15 and STARVE_MAX 1..7");
  end

  arb_latency_counter u_lat_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (LAT_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req_i | mem_req_i) begin
          state_d = ACCESS;
          if (grant_if) begin
            owner_d = OWN_IF;
            we_d    = 1'b0;
            addr_d  = if_addr_i;
            wdata_d = '0;
          end else begin
            owner_d = OWN_MEM;
            we_d    = mem_we_i;
            addr_d  = mem_addr_i;
            wdata_d = mem_wdata_i;
          end
        end
      end
      ACCESS: begin
        cnt_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (cnt_zero) begin
          state_d = RESP;
          // Stores leave the load-data register untouched.
          if (owner_q == OWN_IF) begin
            if_rdata_d = ram_rdata_i;
          end else if (!we_q) begin
            mem_rdata_d = ram_rdata_i;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_en_o    = (state_q == ACCESS);
  assign ram_we_o    = ram_en_o & we_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;

  assign if_ready_o  = (state_q == RESP) && (owner_q == OWN_IF);
  assign mem_ready_o = (state_q == RESP) && (owner_q == OWN_MEM);
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign if_stall_o  = if_req_i & ~if_ready_o;
  assign mem_stall_o = mem_req_i & ~mem_ready_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cycle table, reset and
// fairness sequences, and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned L1   = 1;
  localparam int unsigned L3   = 3;
  localparam int unsigned SMAX = 4;
  localparam int unsigned NVEC = 24;

  localparam logic        Y = 1'b1;
  localparam logic        N = 1'b0;
  localparam logic [31:0] Z = 32'h0;

  logic clk = 1'b0;
  logic reset;
  logic if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;

  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        if_ready, if_stall, mem_ready, mem_stall, ram_en, ram_we;
  logic [31:0] if_rdata3, mem_rdata3, ram_addr3, ram_wdata3;
  logic        if_ready3, if_stall3, mem_ready3, mem_stall3, ram_en3, ram_we3;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(L1), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
    .if_ready_o(if_ready), .if_stall_o(if_stall),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata),
    .mem_ready_o(mem_ready), .mem_stall_o(mem_stall),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(L3), .STARVE_MAX(SMAX)) dut3 (
    .clk(clk), .reset(reset),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata3),
    .if_ready_o(if_ready3), .if_stall_o(if_stall3),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata3),
    .mem_ready_o(mem_ready3), .mem_stall_o(mem_stall3),
    .ram_en_o(ram_en3), .ram_we_o(ram_we3), .ram_addr_o(ram_addr3),
    .ram_wdata_o(ram_wdata3), .ram_rdata_i(ram_rdata)
  );

  typedef struct {
    logic        ifr;
    logic [31:0] ifa;
    logic        mr;
    logic        mwe;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic [31:0] rd;
    logic        e_ifrdy;
    logic        e_mrdy;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic        e_ifst;
    logic        e_mst;
    logic [31:0] e_ifd;
    logic [31:0] e_md;
  } vec_t;

  vec_t tbl[NVEC];

  function automatic vec_t mk(
    logic ifr, logic [31:0] ifa, logic mr, logic mwe, logic [31:0] ma,
    logic [31:0] mwd, logic [31:0] rd, logic irdy, logic mrdy, logic en,
    logic we, logic [31:0] addr, logic [31:0] wd, logic ist, logic mst,
    logic [31:0] ifd, logic [31:0] md);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.mr = mr; v.mwe = mwe; v.ma = ma; v.mwd = mwd;
    v.rd = rd; v.e_ifrdy = irdy; v.e_mrdy = mrdy; v.e_en = en; v.e_we = we;
    v.e_addr = addr; v.e_wd = wd; v.e_ifst = ist; v.e_mst = mst;
    v.e_ifd = ifd; v.e_md = md;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_req = 1'b0; if_addr = Z; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = Z; mem_wdata = Z; ram_rdata = Z;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Transaction-level reference state for the randomized run.
  logic        busy, own_mem, t_we, win_if;
  int unsigned g, starve;
  logic [31:0] t_addr, t_wd, m_ifd, m_md;
  logic        e_en, e_we, e_ifr, e_mr, prev_ifr, prev_mr;

  logic        gr_mem[6];
  int unsigned ngr, pulses, en_cnt, rdy_at;
  logic        exp_mem;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // addr/wdata columns matter only on rows where the strobe (and we) is expected.
    tbl[0]  = mk(Y, 32'h0040_0004, N, N, Z, Z, Z,            N, N, N, N, Z, Z, Y, N, Z, Z);
    tbl[1]  = mk(Y, 32'h0040_0004, N, N, Z, Z, Z,            N, N, Y, N, 32'h0040_0004, Z, Y, N, Z, Z);
    tbl[2]  = mk(Y, 32'h0040_0004, N, N, Z, Z, 32'h2008_0005, N, N, N, N, Z, Z, Y, N, Z, Z);
    tbl[3]  = mk(Y, 32'h0040_0004, N, N, Z, Z, Z,            Y, N, N, N, Z, Z, N, N, 32'h2008_0005, Z);
    tbl[4]  = mk(N, Z, N, N, Z, Z, Z,                         N, N, N, N, Z, Z, N, N, 32'h2008_0005, Z);
    tbl[5]  = mk(Y, 32'h0040_0008, Y, N, 32'h1001_0000, Z, Z, N, N, N, N, Z, Z, Y, Y, 32'h2008_0005, Z);
    tbl[6]  = mk(Y, 32'h0040_0008, Y, N, 32'h1001_0000, Z, Z, N, N, Y, N, 32'h1001_0000, Z, Y, Y, 32'h2008_0005, Z);
    tbl[7]  = mk(Y, 32'h0040_0008, Y, N, 32'h1001_0000, Z, 32'h8C09_0000, N, N, N, N, Z, Z, Y, Y, 32'h2008_0005, Z);
    tbl[8]  = mk(Y, 32'h0040_0008, Y, N, 32'h1001_0000, Z, Z, N, Y, N, N, Z, Z, Y, N, 32'h2008_0005, 32'h8C09_0000);
    tbl[9]  = mk(Y, 32'h0040_0008, N, N, Z, Z, Z,            N, N, N, N, Z, Z, Y, N, 32'h2008_0005, 32'h8C09_0000);
    tbl[10] = mk(Y, 32'h0040_0008, N, N, Z, Z, Z,            N, N, Y, N, 32'h0040_0008, Z, Y, N, 32'h2008_0005, 32'h8C09_0000);
    tbl[11] = mk(Y, 32'h0040_0008, N, N, Z, Z, 32'h0109_5020, N, N, N, N, Z, Z, Y, N, 32'h2008_0005, 32'h8C09_0000);
    tbl[12] = mk(Y, 32'h0040_0008, N, N, Z, Z, Z,            Y, N, N, N, Z, Z, N, N, 32'h0109_5020, 32'h8C09_0000);
    tbl[13] = mk(N, Z, N, N, Z, Z, Z,                         N, N, N, N, Z, Z, N, N, 32'h0109_5020, 32'h8C09_0000);
    tbl[14] = mk(N, Z, Y, Y, 32'h1001_0008, 32'hDEAD_BEEF, Z, N, N, N, N, Z, Z, N, Y, 32'h0109_5020, 32'h8C09_0000);
    tbl[15] = mk(N, Z, Y, Y, 32'h1001_0008, 32'hDEAD_BEEF, Z, N, N, Y, Y, 32'h1001_0008, 32'hDEAD_BEEF, N, Y, 32'h0109_5020, 32'h8C09_0000);
    tbl[16] = mk(N, Z, Y, Y, 32'h1001_0008, 32'hDEAD_BEEF, 32'h1234_5678, N, N, N, N, Z, Z, N, Y, 32'h0109_5020, 32'h8C09_0000);
    tbl[17] = mk(N, Z, Y, Y, 32'h1001_0008, 32'hDEAD_BEEF, Z, N, Y, N, N, Z, Z, N, N, 32'h0109_5020, 32'h8C09_0000);
    tbl[18] = mk(N, Z, N, N, Z, Z, Z,                         N, N, N, N, Z, Z, N, N, 32'h0109_5020, 32'h8C09_0000);
    tbl[19] = mk(Y, 32'h0040_000C, N, N, Z, Z, Z,            N, N, N, N, Z, Z, Y, N, 32'h0109_5020, 32'h8C09_0000);
    tbl[20] = mk(N, 32'h0040_000C, N, N, Z, Z, Z,            N, N, Y, N, 32'h0040_000C, Z, N, N, 32'h0109_5020, 32'h8C09_0000);
    tbl[21] = mk(N, 32'h0040_000C, N, N, Z, Z, 32'hAABB_CCDD, N, N, N, N, Z, Z, N, N, 32'h0109_5020, 32'h8C09_0000);
    tbl[22] = mk(N, 32'h0040_000C, N, N, Z, Z, Z,            Y, N, N, N, Z, Z, N, N, 32'hAABB_CCDD, 32'h8C09_0000);
    tbl[23] = mk(N, Z, N, N, Z, Z, Z,                         N, N, N, N, Z, Z, N, N, 32'hAABB_CCDD, 32'h8C09_0000);

    // Reset values
    reset = 1'b1;
    if_req = 1'b0; if_addr = Z; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = Z; mem_wdata = Z; ram_rdata = Z;
    @(negedge clk);
    chk1 ("rst_if_ready", if_ready, N);
    chk1 ("rst_mem_ready", mem_ready, N);
    chk1 ("rst_ram_en", ram_en, N);
    chk1 ("rst_ram_we", ram_we, N);
    chk1 ("rst_if_stall", if_stall, N);
    chk1 ("rst_mem_stall", mem_stall, N);
    chk32("rst_ram_addr", ram_addr, Z);
    chk32("rst_ram_wdata", ram_wdata, Z);
    chk32("rst_if_rdata", if_rdata, Z);
    chk32("rst_mem_rdata", mem_rdata, Z);
    chk1 ("rst3_ram_en", ram_en3, N);

    // Reset in the middle of a LATENCY=3 read
    do_reset();
    if_req = 1'b1; if_addr = 32'h0040_0010; ram_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("rst3_access_strobe", ram_en3, Y);
    @(posedge clk); #1;
    reset = 1'b1; if_req = 1'b0;
    #1;
    chk1 ("rst3_async_ram_en", ram_en3, N);
    chk1 ("rst3_async_ram_we", ram_we3, N);
    chk1 ("rst3_async_if_ready", if_ready3, N);
    chk1 ("rst3_async_mem_ready", mem_ready3, N);
    chk1 ("rst3_async_if_stall", if_stall3, N);
    chk1 ("rst3_async_mem_stall", mem_stall3, N);
    chk32("rst3_async_ram_addr", ram_addr3, Z);
    chk32("rst3_async_ram_wdata", ram_wdata3, Z);
    chk32("rst3_async_if_rdata", if_rdata3, Z);
    chk32("rst3_async_mem_rdata", mem_rdata3, Z);
    @(posedge clk); #1 reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (if_ready3 || mem_ready3 || ram_en3) pulses++;
      @(posedge clk); #1;
    end
    chk32("rst3_no_stray_pulse", 32'(pulses), Z);
    if_req = 1'b1; if_addr = 32'h0040_0014; ram_rdata = 32'h3C01_1001;
    en_cnt = 0; rdy_at = 99;
    for (int unsigned c = 0; c < 20 && rdy_at == 99; c++) begin
      @(negedge clk);
      if (ram_en3) en_cnt++;
      if (if_ready3) begin
        rdy_at = c;
        chk32("rst3_after_rdata", if_rdata3, 32'h3C01_1001);
      end
      @(posedge clk); #1;
    end
    if_req = 1'b0;
    chk32("rst3_after_ready_cycle", 32'(rdy_at), 32'(L3 + 2));
    chk32("rst3_after_strobe_count", 32'(en_cnt), 32'd1);

    // Directed cycle table, LATENCY=1
    do_reset();
    for (int i = 0; i < int'(NVEC); i++) begin
      if_req = tbl[i].ifr; if_addr = tbl[i].ifa; mem_req = tbl[i].mr;
      mem_we = tbl[i].mwe; mem_addr = tbl[i].ma; mem_wdata = tbl[i].mwd;
      ram_rdata = tbl[i].rd;
      @(negedge clk);
      chk1 ($sformatf("vec%0d_if_ready", i), if_ready, tbl[i].e_ifrdy);
      chk1 ($sformatf("vec%0d_mem_ready", i), mem_ready, tbl[i].e_mrdy);
      chk1 ($sformatf("vec%0d_ram_en", i), ram_en, tbl[i].e_en);
      chk1 ($sformatf("vec%0d_ram_we", i), ram_we, tbl[i].e_we);
      chk1 ($sformatf("vec%0d_if_stall", i), if_stall, tbl[i].e_ifst);
      chk1 ($sformatf("vec%0d_mem_stall", i), mem_stall, tbl[i].e_mst);
      chk32($sformatf("vec%0d_if_rdata", i), if_rdata, tbl[i].e_ifd);
      chk32($sformatf("vec%0d_mem_rdata", i), mem_rdata, tbl[i].e_md);
      if (tbl[i].e_en) chk32($sformatf("vec%0d_ram_addr", i), ram_addr, tbl[i].e_addr);
      if (tbl[i].e_we) chk32($sformatf("vec%0d_ram_wdata", i), ram_wdata, tbl[i].e_wd);
      @(posedge clk); #1;
    end

    // Both requesters held: grant order
    do_reset();
    if_req = 1'b1; if_addr = 32'h0040_0100;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h1001_0100;
    ngr = 0;
    for (int c = 0; c < 80 && ngr < 6; c++) begin
      @(negedge clk);
      if (ram_en) begin
        gr_mem[ngr] = (ram_addr == 32'h1001_0100);
        ngr++;
      end
      @(posedge clk); #1;
    end
    chk32("fair_grant_count", 32'(ngr), 32'd6);
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_FAIR_EN
      exp_mem = ((i % (SMAX + 1)) != SMAX);
`else
      exp_mem = 1'b1;
`endif
      chk1($sformatf("fair_grant%0d_is_mem", i), gr_mem[i], exp_mem);
    end

    // Randomized traffic against the transaction-level model, LATENCY=1
    do_reset();
    busy = 1'b0; own_mem = 1'b0; t_we = 1'b0; g = 0; starve = 0;
    t_addr = Z; t_wd = Z; m_ifd = Z; m_md = Z; prev_ifr = 1'b0; prev_mr = 1'b0;
    for (int unsigned n = 0; n < 400; n++) begin
      ram_rdata = $urandom;
      if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin
          if_req = 1'b1; if_addr = $urandom;
        end
      end else if (prev_ifr) begin
        if ($urandom_range(0, 1) == 0) if_req = 1'b0;
        else if_addr = $urandom;
      end
      if (!mem_req) begin
        if ($urandom_range(0, 2) == 0) begin
          mem_req = 1'b1; mem_we = 1'($urandom_range(0, 1));
          mem_addr = $urandom; mem_wdata = $urandom;
        end
      end else if (prev_mr) begin
        if ($urandom_range(0, 1) == 0) mem_req = 1'b0;
        else begin
          mem_we = 1'($urandom_range(0, 1)); mem_addr = $urandom; mem_wdata = $urandom;
        end
      end

      @(negedge clk);
      e_en  = busy && (n == g + 1);
      e_we  = e_en && t_we;
      e_ifr = busy && !own_mem && (n == g + L1 + 2);
      e_mr  = busy && own_mem && (n == g + L1 + 2);
      chk1 ($sformatf("rnd%0d_ram_en", n), ram_en, e_en);
      chk1 ($sformatf("rnd%0d_ram_we", n), ram_we, e_we);
      chk1 ($sformatf("rnd%0d_if_ready", n), if_ready, e_ifr);
      chk1 ($sformatf("rnd%0d_mem_ready", n), mem_ready, e_mr);
      chk1 ($sformatf("rnd%0d_if_stall", n), if_stall, if_req && !e_ifr);
      chk1 ($sformatf("rnd%0d_mem_stall", n), mem_stall, mem_req && !e_mr);
      chk32($sformatf("rnd%0d_if_rdata", n), if_rdata, m_ifd);
      chk32($sformatf("rnd%0d_mem_rdata", n), mem_rdata, m_md);
      if (e_en) chk32($sformatf("rnd%0d_ram_addr", n), ram_addr, t_addr);
      if (e_we) chk32($sformatf("rnd%0d_ram_wdata", n), ram_wdata, t_wd);

      if (busy) begin
        if (n == g + L1 + 1) begin
          if (!own_mem) m_ifd = ram_rdata;
          else if (!t_we) m_md = ram_rdata;
        end
        if (n == g + L1 + 2) busy = 1'b0;
      end else if (if_req || mem_req) begin
        win_if = if_req && !mem_req;
`ifdef MEM_ARB_FAIR_EN
        if (if_req && mem_req && (starve >= SMAX)) win_if = 1'b1;
        if (win_if) starve = 0;
        else if (if_req) starve++;
`endif
        busy = 1'b1; g = n; own_mem = !win_if;
        t_we   = win_if ? 1'b0 : mem_we;
        t_addr = win_if ? if_addr : mem_addr;
        t_wd   = mem_wdata;
      end
      prev_ifr = e_ifr;
      prev_mr  = e_mr;
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
